seq_detect_param: RTL and testbench



---
 rtl/seq_detect_param.sv | 117 +++++++++++
 tb/tb_seq_detect_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector for an arbitrary compile-time pattern (MSB first),
// with run-time overlap selection and a saturating match counter.
module seq_detect_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b10110,
  parameter int             CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_seq,
  input  logic                  overlap,
  input  logic                  clr_count,
  output logic                  det_out,
  output logic [CNT_W-1:0]      match_count,
  output logic                  count_sat,
  output logic [$clog2(N)-1:0]  st_dbg
);

  localparam int ST_W   = $clog2(N);
  localparam int TAB_SZ = 2 ** (ST_W + 1);

  // Longest prefix of PATTERN that is a suffix of (first s pattern bits, b),
  // excluding the full-length match, which is resolved separately.
  function automatic int calc_next(input int s, input logic b);
    int   len;
    int   res;
    int   j;
    logic ok;
    logic cb;
    len = s + 1;
    res = 0;
    for (int k = 1; k <= len; k++) begin
      if (k < N) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          j  = len - k + i;
          cb = (j == s) ? b : PATTERN[N-1-j];
          if (cb != PATTERN[N-1-i]) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // KMP failure value at N: longest proper prefix that is also a suffix.
  function automatic int calc_fail();
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < N; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (PATTERN[N-1-i] != PATTERN[k-1-i]) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  localparam logic [ST_W-1:0] FAIL_ST = ST_W'(calc_fail());
  localparam logic [ST_W-1:0] LAST_ST = ST_W'(N - 1);

  // Next-state table indexed by {st, bit}; entries for st >= N are unreachable.
  logic [ST_W-1:0] nxt_tab [TAB_SZ];

  for (genvar g = 0; g < TAB_SZ; g++) begin : g_tab
    if ((g / 2) < N) begin : g_live
      localparam int NX = calc_next(g / 2, 1'(g % 2));
      assign nxt_tab[g] = ST_W'(NX);
    end else begin : g_dead
      assign nxt_tab[g] = '0;
    end
  end

  logic [ST_W-1:0]  st_q, st_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             match;

  always_comb begin
    st_d  = st_q;
    match = 1'b0;
    if (in_valid) begin
      match = (st_q == LAST_ST) && (in_seq == PATTERN[0]);
      if (match) st_d = overlap ? FAIL_ST : '0;
      else       st_d = nxt_tab[{st_q, in_seq}];
    end
    // Clear takes effect before a same-cycle increment.
    cnt_d = clr_count ? '0 : cnt_q;
    if (match && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
    det_d = match;
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= '0;
      det_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      det_q <= det_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign det_out     = det_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;
  assign st_dbg      = st_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed vectors on three parameterisations
// plus a random stream checked against a last-N-bits reference model.
module tb_seq_detect_param;

  localparam logic [4:0] PAT = 5'b10110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_seq = 1'b0;
  logic overlap = 1'b1;
  logic clr_count = 1'b0;

  logic       d_det, p_det, c_det;
  logic [7:0] d_cnt, p_cnt;
  logic [1:0] c_cnt;
  logic       d_sat, p_sat, c_sat;
  logic [2:0] d_st, c_st;
  logic [1:0] p_st;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.N(5), .PATTERN(5'b10110), .CNT_W(8)) u_dflt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .overlap(overlap),
    .clr_count(clr_count), .det_out(d_det), .match_count(d_cnt), .count_sat(d_sat),
    .st_dbg(d_st));

  seq_detect_param #(.N(3), .PATTERN(3'b111), .CNT_W(8)) u_p3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .overlap(overlap),
    .clr_count(clr_count), .det_out(p_det), .match_count(p_cnt), .count_sat(p_sat),
    .st_dbg(p_st));

  seq_detect_param #(.N(5), .PATTERN(5'b10110), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .overlap(overlap),
    .clr_count(clr_count), .det_out(c_det), .match_count(c_cnt), .count_sat(c_sat),
    .st_dbg(c_st));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic v, input logic b, input logic ov, input logic clr, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_seq    = b;
    overlap   = ov;
    clr_count = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, overlap, 1'b0, 1'b1);
    drive(1'b0, 1'b0, overlap, 1'b0, 1'b1);
  endtask

  function automatic logic det_of(input int d);
    case (d)
      0:       return d_det;
      1:       return p_det;
      default: return c_det;
    endcase
  endfunction

  // bits: '0'/'1' accepted bits, '-' an idle cycle; exp: '1' where det_out must pulse.
  task automatic run_seq(input string tag, input int d, input string bits, input string exp,
                         input logic ov);
    for (int i = 0; i < bits.len(); i++) begin
      drive(bits[i] != "-", bits[i] == "1", ov, 1'b0, 1'b0);
      check($sformatf("%s_det%0d", tag, i), 32'(det_of(d)), 32'(exp[i] == "1"));
    end
  endtask

  int   exp_cnt_tab [5] = '{1, 2, 3, 3, 3};
  logic exp_sat_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [4:0] m_hist;
  int         m_len;
  int         m_cnt;
  logic       m_det;
  logic       r_v, r_b, r_ov;

  initial begin
    do_reset();
    check("rst_det", 32'(d_det), 32'd0);
    check("rst_cnt", 32'(d_cnt), 32'd0);
    check("rst_sat", 32'(d_sat), 32'd0);
    check("rst_st",  32'(d_st),  32'd0);

    // Overlapping and non-overlapping default stream
    do_reset();
    run_seq("ovl", 0, "10110110", "00001001", 1'b1);
    check("ovl_cnt", 32'(d_cnt), 32'd2);
    do_reset();
    run_seq("nov", 0, "10110110", "00001000", 1'b0);
    check("nov_cnt", 32'(d_cnt), 32'd1);

    // Gaps keep a partial match; reset discards it
    do_reset();
    run_seq("gap", 0, "1---0---1---1---0", "00000000000000001", 1'b1);
    check("gap_cnt", 32'(d_cnt), 32'd1);
    do_reset();
    run_seq("grs_a", 0, "1---0---1", "000000000", 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("grs_rstdet", 32'(d_det), 32'd0);
    run_seq("grs_b", 0, "10", "00", 1'b1);
    run_seq("grs_c", 0, "10110", "00001", 1'b1);
    check("grs_cnt", 32'(d_cnt), 32'd1);

    // Reset beats a completing bit in the same cycle
    do_reset();
    run_seq("rov", 0, "1011", "0000", 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rov_det", 32'(d_det), 32'd0);
    check("rov_cnt", 32'(d_cnt), 32'd0);
    run_seq("rov_b", 0, "0", "0", 1'b1);

    // N=3, PATTERN=111
    do_reset();
    run_seq("p3o", 1, "111111", "001111", 1'b1);
    check("p3o_cnt", 32'(p_cnt), 32'd4);
    do_reset();
    run_seq("p3n", 1, "111111", "001001", 1'b0);
    check("p3n_cnt", 32'(p_cnt), 32'd2);

    // CNT_W=2 saturation and clear
    do_reset();
    for (int m = 0; m < 5; m++) begin
      if (m == 0) run_seq("sat", 2, "10110", "00001", 1'b1);
      else        run_seq("sat", 2, "110", "001", 1'b1);
      check($sformatf("sat_cnt%0d", m), 32'(c_cnt), 32'(exp_cnt_tab[m]));
      check($sformatf("sat_sat%0d", m), 32'(c_sat), 32'(exp_sat_tab[m]));
    end
    run_seq("clrm", 2, "11", "00", 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clrm_det", 32'(c_det), 32'd1);
    check("clrm_cnt", 32'(c_cnt), 32'd1);
    check("clrm_sat", 32'(c_sat), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_cnt", 32'(c_cnt), 32'd0);
    check("clr_det", 32'(c_det), 32'd0);

    // Random stream against a last-N-accepted-bits model
    do_reset();
    m_hist = '0;
    m_len  = 0;
    m_cnt  = 0;
    r_ov   = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r_v = ($urandom_range(0, 3) != 0);
      r_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) r_ov = ~r_ov;
      m_det = 1'b0;
      if (r_v) begin
        m_hist = {m_hist[3:0], r_b};
        if (m_len < 5) m_len++;
        if (m_len == 5 && m_hist == PAT) begin
          m_det = 1'b1;
          if (m_cnt < 255) m_cnt++;
          if (!r_ov) m_len = 0;
        end
      end
      drive(r_v, r_b, r_ov, 1'b0, 1'b0);
      check($sformatf("rnd_det%0d", i), 32'(d_det), 32'(m_det));
      check($sformatf("rnd_cnt%0d", i), 32'(d_cnt), 32'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
